debouncer_array: RTL and testbench
==================================

DEBOUNCER_ARRAY -- requirements
Module: debouncer_array

Interface
REQ-001 The block SHALL have parameter Channels, default 4, number of independent switch inputs (>=1).
REQ-002 The block SHALL have parameter ClkRate, default 10_000_000, clock frequency in Hz.
REQ-003 The block SHALL have parameter SampleRate, default 1_000_000, sample-strobe frequency in Hz; Div = ClkRate/SampleRate SHALL be an integer >=1, else elaboration error.
REQ-004 The block SHALL have parameter StableCount, default 4, consecutive differing samples required to accept a change (>=1).
REQ-005 The block SHALL have parameter InvertMask [Channels-1:0], default '0, per-channel input inversion, with bit=1 meaning active-low switch.
REQ-006 The block SHALL have port clk_i, input, 1, the single clock.
REQ-007 The block SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port sw_i, input, Channels, raw asynchronous switch inputs.
REQ-009 The block SHALL have port db_level_o, output, Channels, debounced level per channel.
REQ-010 The block SHALL have port db_rise_o, output, Channels, one-cycle pulse when a channel's debounced level goes 0->1.
REQ-011 The block SHALL have port db_fall_o, output, Channels, one-cycle pulse when a channel's debounced level goes 1->0.
REQ-012 The block SHALL have port any_tick_o, output, 1, OR of all db_rise_o and db_fall_o bits.

Function
REQ-013 Each sw_i bit SHALL pass through a 2-flop synchronizer, then be XORed with its InvertMask bit to form s[i].
REQ-014 A single shared prescaler SHALL count 0..Div-1 and assert strobe for exactly one cycle when the count equals Div-1, then wrap to 0; with Div=1, strobe SHALL be asserted every cycle.
REQ-015 Each channel SHALL have a two-state FSM: STABLE and PENDING.
REQ-016 In STABLE, on strobe with s[i]!=level[i], the FSM SHALL go to PENDING with cnt=1; if StableCount=1, the level SHALL instead flip immediately and the FSM SHALL stay in STABLE.
REQ-017 In PENDING, on strobe with s[i]==level[i], the FSM SHALL return to STABLE with cnt=0, and no output change SHALL occur (glitch rejected).
REQ-018 In PENDING, on strobe with s[i]!=level[i] and cnt+1==StableCount, level[i] SHALL toggle, cnt SHALL clear, and the FSM SHALL return to STABLE.
REQ-019 In PENDING, on strobe with s[i]!=level[i] and cnt+1<StableCount, cnt SHALL increment.
REQ-020 Between strobes, FSM state and cnt SHALL hold.
REQ-021 db_level_o, db_rise_o, db_fall_o and any_tick_o SHALL all be registered outputs; rise/fall SHALL assert in the same cycle the new db_level_o value first appears, for exactly one cycle.
REQ-022 cnt SHALL be $clog2(StableCount+1) bits wide and SHALL never exceed StableCount-1.
REQ-023 Channels SHALL be fully independent, and simultaneous acceptance on several channels SHALL pulse all corresponding bits in the same cycle.
REQ-024 Latency from a clean sw_i edge to db_level_o change SHALL be between 3+(StableCount-1)*Div and 3+StableCount*Div cycles.

Reset
REQ-025 While rst_i=1, level[i] SHALL be InvertMask[i] (logical "released"), every FSM SHALL be in STABLE with cnt=0, the synchronizer flops SHALL hold InvertMask, the prescaler SHALL be 0, and all pulse outputs SHALL be 0.
REQ-026 Reset asserted mid-PENDING SHALL discard the pending change; after release, the first strobe SHALL occur Div cycles later.

Structure
REQ-027 Package debouncer_pkg SHALL hold the default-parameter constants and a function computing Div and the counter width.
REQ-028 Per-channel logic (synchronizer, FSM, counter, edge pulses) SHALL be sub-module debounce_channel, instantiated Channels times under a generate loop; the prescaler SHALL stay in the top level.

Verification (Channels=4, ClkRate=10_000_000, SampleRate=1_000_000, StableCount=4, Div=10)
REQ-029 Clean press: hold sw_i[0] 0->1 -> db_level_o[0] rises within 33..43 cycles, db_rise_o[0] and any_tick_o pulse exactly once for 1 cycle, and the other channels stay unchanged.
REQ-030 Bounce: toggle sw_i[1] high for 25 cycles then low -> no change on db_level_o[1], and zero pulses.
REQ-031 Simultaneous: release sw_i[2] and press sw_i[3] on the same cycle -> db_fall_o[2] and db_rise_o[3] pulse in the same cycle, and any_tick_o pulses once.
REQ-032 Inversion: InvertMask=4'b0001, sw_i[0]=1 at reset -> db_level_o[0]=0 after reset; drive sw_i[0]=0 for 50 cycles -> db_level_o[0]=1.
REQ-033 Reset mid-pending: press sw_i[0], assert rst_i after 25 cycles for 3 cycles, keep sw_i[0]=1 -> no pulse during reset, and db_level_o[0] rises 33..43 cycles after rst_i falls.

Source files
------------

// File: rtl/debouncer_pkg.sv
// ============================================================================
// Module : debouncer_pkg
// Brief  : Shared defaults, FSM state type and sizing helpers for debouncer_array
// Rev    : 1.0
// ============================================================================
`default_nettype none

package debouncer_pkg;

    localparam int DEFAULT_CHANNELS     = 4;
    localparam int DEFAULT_CLK_RATE     = 10_000_000;
    localparam int DEFAULT_SAMPLE_RATE  = 1_000_000;
    localparam int DEFAULT_STABLE_COUNT = 4;

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    function automatic int calc_div(input int clk_rate, input int sample_rate);
        return (sample_rate > 0) ? (clk_rate / sample_rate) : 0;
    endfunction

    function automatic int cnt_width(input int stable_count);
        return $clog2(stable_count + 1);
    endfunction

    // A one-state prescaler still needs a 1-bit register to stay legal.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module : debounce_channel
// Brief  : One switch channel: 2-flop sync, STABLE/PENDING filter, edge pulses
// Rev    : 1.0
// ============================================================================
`default_nettype none

module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int   StableCount = DEFAULT_STABLE_COUNT,
    parameter logic InvertBit   = 1'b0,
    parameter int   CntW        = cnt_width(StableCount)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_i,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_next_o
);

    logic [1:0]      sync_q;
    db_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            s;

    assign s = sync_q[1] ^ InvertBit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= {2{InvertBit}};
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= InvertBit;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], sw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (strobe_i) begin
            case (state_q)
                ST_STABLE: begin
                    if (s != level_q) begin
                        if (StableCount == 1) begin
                            level_d = ~level_q;
                        end else begin
                            state_d = ST_PENDING;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (s == level_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q + CntW'(1) == CntW'(StableCount)) begin
                        level_d = ~level_q;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    assign level_o     = level_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    // Lets the top register its OR-of-edges in step with rise_q/fall_q.
    assign edge_next_o = rise_d | fall_d;

endmodule

`default_nettype wire

// File: rtl/debouncer_array.sv
// ============================================================================
// Module : debouncer_array
// Brief  : Multi-channel switch debouncer sharing one sample-strobe prescaler
// Rev    : 1.0
// ============================================================================
`default_nettype none

module debouncer_array
    import debouncer_pkg::*;
#(
    parameter int                  Channels    = DEFAULT_CHANNELS,
    parameter int                  ClkRate     = DEFAULT_CLK_RATE,
    parameter int                  SampleRate  = DEFAULT_SAMPLE_RATE,
    parameter int                  StableCount = DEFAULT_STABLE_COUNT,
    parameter logic [Channels-1:0] InvertMask  = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Channels-1:0] sw_i,
    output logic [Channels-1:0] db_level_o,
    output logic [Channels-1:0] db_rise_o,
    output logic [Channels-1:0] db_fall_o,
    output logic                any_tick_o
);

    localparam int SafeRate = (SampleRate < 1) ? 1 : SampleRate;
    localparam int Div      = calc_div(ClkRate, SafeRate);
    localparam int PrescW   = presc_width(Div);

    generate
        if ((SampleRate < 1) || (ClkRate % SafeRate != 0) || (Div < 1) ||
            (Channels < 1) || (StableCount < 1)) begin : g_param_error
            $error("debouncer_array: illegal parameter combination");
        end
    endgenerate

    logic [PrescW-1:0]   presc_q, presc_d;
    logic                strobe;
    logic [Channels-1:0] edge_next;
    logic                any_tick_q;

    assign strobe  = (presc_q == PrescW'(Div - 1));
    assign presc_d = strobe ? '0 : presc_q + PrescW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q    <= '0;
            any_tick_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            any_tick_q <= |edge_next;
        end
    end

    generate
        for (genvar g = 0; g < Channels; g++) begin : g_channel
            debounce_channel #(
                .StableCount (StableCount),
                .InvertBit   (InvertMask[g])
            ) u_channel (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .strobe_i    (strobe),
                .sw_i        (sw_i[g]),
                .level_o     (db_level_o[g]),
                .rise_o      (db_rise_o[g]),
                .fall_o      (db_fall_o[g]),
                .edge_next_o (edge_next[g])
            );
        end
    endgenerate

    assign any_tick_o = any_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_debouncer_array.sv
// ============================================================================
// Module : tb_debouncer_array
// Brief  : Directed checks of debouncer_array (plain and inverted instances)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_debouncer_array;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_a, rst_b;
    logic [CH-1:0] sw_a, sw_b;
    logic [CH-1:0] lvl_a, rise_a, fall_a;
    logic [CH-1:0] lvl_b, rise_b, fall_b;
    logic          tick_a, tick_b;

    always #5 clk = ~clk;

    debouncer_array #(
        .Channels(CH), .ClkRate(10_000_000), .SampleRate(1_000_000),
        .StableCount(4), .InvertMask(4'b0000)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_a), .sw_i(sw_a), .db_level_o(lvl_a),
        .db_rise_o(rise_a), .db_fall_o(fall_a), .any_tick_o(tick_a)
    );

    debouncer_array #(
        .Channels(CH), .ClkRate(10_000_000), .SampleRate(1_000_000),
        .StableCount(4), .InvertMask(4'b0001)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_b), .sw_i(sw_b), .db_level_o(lvl_b),
        .db_rise_o(rise_b), .db_fall_o(fall_b), .any_tick_o(tick_b)
    );

    // Pulse accounting for dut_a; mon_err counts pulses that do not match a level edge.
    int            rise_cnt [CH] = '{default: 0};
    int            fall_cnt [CH] = '{default: 0};
    int            rise_all = 0;
    int            fall_all = 0;
    int            tick_cnt = 0;
    int            mon_err  = 0;
    logic [CH-1:0] prev_lvl = '0;
    logic          mon_en   = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < CH; i++) begin
                if (rise_a[i]) begin
                    rise_cnt[i] <= rise_cnt[i] + 1;
                    if (!(lvl_a[i] && !prev_lvl[i])) mon_err <= mon_err + 1;
                end
                if (fall_a[i]) begin
                    fall_cnt[i] <= fall_cnt[i] + 1;
                    if (!(!lvl_a[i] && prev_lvl[i])) mon_err <= mon_err + 1;
                end
            end
            rise_all <= rise_all + $countones(rise_a);
            fall_all <= fall_all + $countones(fall_a);
            if (tick_a) tick_cnt <= tick_cnt + 1;
            if (tick_a != |(rise_a | fall_a)) mon_err <= mon_err + 1;
            prev_lvl <= lvl_a;
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [CH-1:0] sw;
        int            hold;
        logic [CH-1:0] lvl;
        int            rises;
        int            falls;
        int            ticks;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int lat, r0, f0, t0;

        tbl[0] = '{4'b0101, 60, 4'b0101, 1, 0, 1};
        tbl[1] = '{4'b1010, 60, 4'b1010, 2, 2, 1};
        tbl[2] = '{4'b1111, 60, 4'b1111, 2, 0, 1};
        tbl[3] = '{4'b0000,  5, 4'b1111, 0, 0, 0};
        tbl[4] = '{4'b1111, 60, 4'b1111, 0, 0, 0};
        tbl[5] = '{4'b0000, 60, 4'b0000, 0, 4, 1};

        sw_a  = '0;
        sw_b  = 4'b0001;
        rst_a = 1'b1;
        rst_b = 1'b1;
        wait_cycles(3);
        check("reset_level_a", 32'(lvl_a), 32'(4'b0000));
        check("reset_pulses_a", 32'({rise_a, fall_a, tick_a}), 32'd0);
        check("reset_level_b", 32'(lvl_b), 32'(4'b0001));
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        mon_en = 1'b1;

        // Inverted channel: idle-high input settles to level 0, driving it low gives 1.
        wait_cycles(60);
        check("inv_settle_b", 32'(lvl_b), 32'(4'b0000));
        sw_b = 4'b0000;
        wait_cycles(50);
        check("inv_press_b", 32'(lvl_b), 32'(4'b0001));

        // Clean press on channel 0.
        r0 = rise_cnt[0];
        t0 = tick_cnt;
        sw_a[0] = 1'b1;
        lat = 0;
        while (!lvl_a[0] && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check_range("press_latency", lat, 33, 43);
        wait_cycles(5);
        check("press_rise_count", 32'(rise_cnt[0] - r0), 32'd1);
        check("press_tick_count", 32'(tick_cnt - t0), 32'd1);
        check("press_other_levels", 32'(lvl_a[3:1]), 32'd0);

        // Bounce on channel 1: 25 cycles high is shorter than four strobes.
        r0 = rise_cnt[1] + fall_cnt[1];
        t0 = tick_cnt;
        sw_a[1] = 1'b1;
        wait_cycles(25);
        sw_a[1] = 1'b0;
        wait_cycles(60);
        check("bounce_level", 32'(lvl_a[1]), 32'd0);
        check("bounce_pulses", 32'(rise_cnt[1] + fall_cnt[1] - r0), 32'd0);
        check("bounce_ticks", 32'(tick_cnt - t0), 32'd0);

        // Simultaneous release of ch2 and press of ch3.
        sw_a[2] = 1'b1;
        wait_cycles(60);
        check("simul_setup", 32'(lvl_a), 32'(4'b0101));
        t0 = tick_cnt;
        sw_a[2] = 1'b0;
        sw_a[3] = 1'b1;
        lat = 0;
        while (!tick_a && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("simul_pulse_pair", 32'({fall_a[2], rise_a[3]}), 32'(2'b11));
        wait_cycles(60);
        check("simul_tick_count", 32'(tick_cnt - t0), 32'd1);
        check("simul_levels", 32'(lvl_a), 32'(4'b1001));

        // Reset in the middle of a pending press.
        sw_a = '0;
        wait_cycles(60);
        check("rstmid_idle", 32'(lvl_a), 32'd0);
        r0 = rise_all + fall_all;
        sw_a[0] = 1'b1;
        wait_cycles(25);
        rst_a = 1'b1;
        wait_cycles(3);
        check("rstmid_level_in_reset", 32'(lvl_a), 32'd0);
        check("rstmid_no_pulse", 32'(rise_all + fall_all - r0), 32'd0);
        rst_a = 1'b0;
        lat = 0;
        while (!lvl_a[0] && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check_range("rstmid_latency", lat, 33, 43);
        wait_cycles(20);

        // Table of settled patterns and one short glitch.
        for (int k = 0; k < 6; k++) begin
            r0 = rise_all;
            f0 = fall_all;
            t0 = tick_cnt;
            sw_a = tbl[k].sw;
            wait_cycles(tbl[k].hold);
            check($sformatf("tbl%0d_level", k), 32'(lvl_a), 32'(tbl[k].lvl));
            check($sformatf("tbl%0d_rises", k), 32'(rise_all - r0), 32'(tbl[k].rises));
            check($sformatf("tbl%0d_falls", k), 32'(fall_all - f0), 32'(tbl[k].falls));
            check($sformatf("tbl%0d_ticks", k), 32'(tick_cnt - t0), 32'(tbl[k].ticks));
        end

        wait_cycles(2);
        check("pulse_consistency", 32'(mon_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
